lcd_seq_ctrl: RTL and testbench
===============================

Name: lcd_seq_ctrl

Overview:
- Sequencer that owns the HD44780-style character LCD bus (lcd_e, lcd_rs, data) on the DE2 board.
- Runs the power-on init sequence, then rewrites both 16-character lines whenever a refresh is requested.
- Sits between the formatting logic (decimal digits of sum and remaining n, already converted to ASCII) and the LCD pins.
- Serialises all bus traffic so the datapath never drives the LCD directly.

Parameters:
- PWR_WAIT, 750000, cycles idle after reset before the first command (15 ms @ 50 MHz)
- SETUP, 2, cycles RS/data are stable before lcd_e rises
- E_HIGH, 12, cycles lcd_e is held high per byte
- CMD_WAIT, 2000, cycles lcd_e is held low after a normal byte (40 us)
- CLR_WAIT, 82000, cycles lcd_e is held low after the clear command 0x01 (1.64 ms)

Ports:
- clk_i  in  1  system clock (CLOCK_50)
- rst_ni  in  1  asynchronous active-low reset
- line1_i  in  128  top-line ASCII; char k (k=0 leftmost) at [8k+7:8k]
- line2_i  in  128  bottom-line ASCII, same packing
- refresh_req_i  in  1  level request to rewrite both lines
- refresh_ack_o  out  1  one-cycle pulse when a request is accepted and the lines are snapshotted
- busy_o  out  1  high in every state except IDLE
- init_done_o  out  1  high once the init sequence has completed; stays high until reset
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = character data
- data  out  8  LCD data bus

Behaviour:
- Reset: one clock, asynchronous active-low reset, clock clk_i, reset rst_ni.
  - While rst_ni=0: lcd_e=0, lcd_rs=0, data=8'h00, refresh_ack_o=0, init_done_o=0, busy_o=1, pending=1, state=PWR.
  - Assertion mid-byte or mid-refresh aborts immediately. After release the full init sequence restarts from PWR.
- Byte engine (shared by all states): each byte has three phases.
  - SETUP cycles: lcd_e=0, with lcd_rs/data driven.
  - E_HIGH cycles: lcd_e=1.
  - WAIT cycles: lcd_e=0. WAIT is CLR_WAIT for command 0x01 and CMD_WAIT otherwise.
  - lcd_rs and data stay constant across all three phases and hold their last value between bytes.
- States:
  - PWR: count PWR_WAIT cycles, then go to INIT.
  - INIT: send commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, all with lcd_rs=0. Then set init_done_o=1 and go to IDLE.
  - IDLE: busy_o=0. If pending=1 or refresh_req_i=1:
    - snapshot line1_i/line2_i into internal buffers;
    - pulse refresh_ack_o for exactly that cycle;
    - clear pending;
    - go to REFRESH next cycle.
  - REFRESH: send 34 bytes in order, then return to IDLE:
    - 0x80 (lcd_rs=0);
    - line1 chars 0..15 (lcd_rs=1);
    - 0xC0 (lcd_rs=0);
    - line2 chars 0..15 (lcd_rs=1).
- Pending:
  - Set at reset, so the first refresh happens automatically after init.
  - Also set when refresh_req_i=1 in any state other than IDLE.
  - Cleared only by acceptance.
  - Several requests while busy collapse into one refresh.
- Snapshot: the bus shows the line contents from the acceptance cycle. Input changes during REFRESH do not affect the current pass.
- Latency:
  - Acceptance occurs in the first IDLE cycle in which a request is seen.
  - The first REFRESH byte setup starts one cycle after acceptance.
  - A refresh lasts exactly 34*(SETUP+E_HIGH+CMD_WAIT) cycles.
- Counters are sized for the largest parameter. Parameters are assumed ≥1; no overflow or wrap-around is allowed.
- refresh_req_i held high continuously causes back-to-back refreshes with one IDLE cycle between them.

Test Plan:
Bench parameters: PWR_WAIT=20, SETUP=1, E_HIGH=2, CMD_WAIT=5, CLR_WAIT=10, so a normal byte takes 8 cycles.
- Reset hold and release, refresh_req_i=0 -> outputs match the reset values; lcd_e first rises 21 cycles after release; INIT bytes are 38,38,38,0C,01,06 with lcd_rs=0; the 0x01 byte is 13 cycles long; init_done_o rises after 73 cycles.
- Continue the first scenario with line1="SUM=00000255    " and line2="N=003           " -> automatic refresh with refresh_ack_o pulsed once; the bus shows 80, the 16 line1 ASCII bytes (lcd_rs=1), C0, the 16 line2 bytes; 272 cycles long; busy_o then falls.
- In IDLE, pulse refresh_req_i for 1 cycle, then change line1 during the refresh -> the bus carries the old snapshot; exactly one refresh_ack_o pulse.
- Raise refresh_req_i 3 times during one refresh -> exactly one further refresh follows, starting 1 cycle after the first returns to IDLE.
- Assert rst_ni=0 in the middle of REFRESH while lcd_e=1 -> lcd_e, lcd_rs, data and init_done_o drop to 0 in the same cycle without waiting for a clock edge; after release the PWR/INIT sequence repeats.
- Hold refresh_req_i=1 continuously -> refreshes repeat every 273 cycles with a refresh_ack_o pulse at each start.

Source files
------------

// File: rtl/lcd_seq_ctrl.sv
// HD44780 character LCD sequencer: power-on wait, init commands, two-line refresh.
// Ports: clk_i/rst_ni, line1_i/line2_i (16 ASCII chars each, char 0 in [7:0]),
//   refresh_req_i/refresh_ack_o handshake, busy_o, init_done_o, lcd_e/lcd_rs/data LCD bus.
module lcd_seq_ctrl #(
  parameter int PWR_WAIT = 750000,
  parameter int SETUP    = 2,
  parameter int E_HIGH   = 12,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 82000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [127:0] line1_i,
  input  logic [127:0] line2_i,
  input  logic         refresh_req_i,
  output logic         refresh_ack_o,
  output logic         busy_o,
  output logic         init_done_o,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic [7:0]   data
);

  localparam int M1 = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int M2 = (SETUP > E_HIGH) ? SETUP : E_HIGH;
  localparam int M3 = (M2 > CMD_WAIT) ? M2 : CMD_WAIT;
  localparam int MAX_P = (M1 > M3) ? M1 : M3;
  localparam int CW = $clog2(MAX_P + 1);

  typedef enum logic [1:0] {
    S_PWR, S_INIT, S_IDLE, S_REFRESH
  } state_e;

  typedef enum logic [1:0] {
    P_SETUP, P_HIGH, P_WAIT
  } phase_e;

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic          pending_q, pending_d;
  logic          init_done_q, init_done_d;
  logic [127:0]  line1_q, line1_d;
  logic [127:0]  line2_q, line2_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;

  logic          active;
  logic          cur_rs;
  logic [7:0]    cur_byte;
  logic [3:0]    ch1, ch2;
  logic [CW-1:0] lim;
  logic          cnt_last;
  logic          byte_done;
  logic          last_idx;
  logic          accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_PWR;
      phase_q     <= P_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      pending_q   <= 1'b1;
      init_done_q <= 1'b0;
      line1_q     <= '0;
      line2_q     <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  // Byte selection: idx 0..5 in INIT; 0..33 in REFRESH.
  // Low idx bits minus 1 / minus 2 give the char slot for each line.
  always_comb begin
    ch1      = idx_q[3:0] - 4'd1;
    ch2      = idx_q[3:0] - 4'd2;
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    if (state_q == S_INIT) begin
      case (idx_q)
        6'd0, 6'd1, 6'd2: cur_byte = 8'h38;
        6'd3:             cur_byte = 8'h0C;
        6'd4:             cur_byte = 8'h01;
        default:          cur_byte = 8'h06;
      endcase
    end else if (state_q == S_REFRESH) begin
      if (idx_q == 6'd0) begin
        cur_byte = 8'h80;
      end else if (idx_q <= 6'd16) begin
        cur_rs   = 1'b1;
        cur_byte = line1_q[{ch1, 3'b000} +: 8];
      end else if (idx_q == 6'd17) begin
        cur_byte = 8'hC0;
      end else begin
        cur_rs   = 1'b1;
        cur_byte = line2_q[{ch2, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    active = (state_q == S_INIT) || (state_q == S_REFRESH);
    // Bus holds its last value outside of byte transfers.
    rs_d   = active ? cur_rs : rs_q;
    data_d = active ? cur_byte : data_q;
    unique case (phase_q)
      P_SETUP: lim = CW'(SETUP - 1);
      P_HIGH:  lim = CW'(E_HIGH - 1);
      default: lim = (!cur_rs && cur_byte == 8'h01) ?
                     CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
    endcase
    cnt_last  = (cnt_q == lim);
    byte_done = active && (phase_q == P_WAIT) && cnt_last;
    last_idx  = (state_q == S_INIT) ? (idx_q == 6'd5)
                                    : (idx_q == 6'd33);
    accept    = (state_q == S_IDLE) && (pending_q || refresh_req_i);
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    line1_d     = line1_q;
    line2_d     = line2_q;
    pending_d   = pending_q;
    if (accept) begin
      pending_d = 1'b0;
    end else if (state_q != S_IDLE && refresh_req_i) begin
      pending_d = 1'b1;
    end
    case (state_q)
      S_PWR: begin
        if (cnt_q == CW'(PWR_WAIT - 1)) begin
          state_d = S_INIT;
          cnt_d   = '0;
          phase_d = P_SETUP;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT, S_REFRESH: begin
        if (cnt_last) begin
          cnt_d = '0;
          unique case (phase_q)
            P_SETUP: phase_d = P_HIGH;
            P_HIGH:  phase_d = P_WAIT;
            default: begin
              phase_d = P_SETUP;
              idx_d   = idx_q + 6'd1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (byte_done && last_idx) begin
          state_d = S_IDLE;
          idx_d   = '0;
          if (state_q == S_INIT) begin
            init_done_d = 1'b1;
          end
        end
      end
      default: begin
        if (accept) begin
          state_d = S_REFRESH;
          line1_d = line1_i;
          line2_d = line2_i;
          cnt_d   = '0;
          phase_d = P_SETUP;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    refresh_ack_o = accept;
    busy_o        = (state_q != S_IDLE);
    init_done_o   = init_done_q;
    lcd_e         = active && (phase_q == P_HIGH);
    lcd_rs        = rs_q;
    data          = data_q;
    if (active) begin
      lcd_rs = cur_rs;
      data   = cur_byte;
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl with shortened timing parameters.
// Normal byte = 8 cycles, clear byte = 13 cycles, refresh = 272 cycles.
module tb_lcd_seq_ctrl;

  localparam int PW = 20;
  localparam int ST = 1;
  localparam int EH = 2;
  localparam int CM = 5;
  localparam int CL = 10;

  localparam string L1  = "SUM=00000255    ";
  localparam string L1B = "NEW LINE ONE!!!!";
  localparam string L2  = "N=003           ";

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [127:0] line1_i;
  logic [127:0] line2_i;
  logic         refresh_req_i;
  logic         refresh_ack_o;
  logic         busy_o;
  logic         init_done_o;
  logic         lcd_e;
  logic         lcd_rs;
  logic [7:0]   data;

  always #5 clk = ~clk;

  lcd_seq_ctrl #(
    .PWR_WAIT(PW), .SETUP(ST), .E_HIGH(EH),
    .CMD_WAIT(CM), .CLR_WAIT(CL)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .line1_i(line1_i),
    .line2_i(line2_i),
    .refresh_req_i(refresh_req_i),
    .refresh_ack_o(refresh_ack_o),
    .busy_o(busy_o),
    .init_done_o(init_done_o),
    .lcd_e(lcd_e),
    .lcd_rs(lcd_rs),
    .data(data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] bq[$];
  int         tq[$];
  logic       e_prev = 1'b0;
  int         acks = 0;

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      bq.push_back({lcd_rs, data});
      tq.push_back(cyc);
    end
    e_prev <= lcd_e;
    if (refresh_ack_o) acks <= acks + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input string s);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = s[k];
    return v;
  endfunction

  // sel: 0 init_done high, 1 busy low, 2 lcd_e high, 3 ack high
  task automatic wait_for(input int sel, input int lim, output int t);
    logic hit;
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      hit = (sel == 0 && init_done_o) || (sel == 1 && !busy_o) ||
            (sel == 2 && lcd_e) || (sel == 3 && refresh_ack_o);
      if (hit) begin
        t = cyc;
        break;
      end
    end
    chk($sformatf("wait_sel%0d_timeout", sel), 32'(t != -1), 1);
  endtask

  task automatic pulse_req();
    @(posedge clk);
    #2 refresh_req_i = 1'b1;
    @(posedge clk);
    #2 refresh_req_i = 1'b0;
  endtask

  task automatic check_init();
    logic [7:0] ib [6];
    ib = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    chk("init_count", bq.size(), 6);
    if (bq.size() == 6) begin
      for (int i = 0; i < 6; i++)
        chk($sformatf("init_byte%0d", i), bq[i], {1'b0, ib[i]});
      chk("init_norm_len", tq[1] - tq[0], 8);
      chk("init_clr_len", tq[5] - tq[4], 13);
    end
  endtask

  task automatic check_refresh(input int base, input string l1,
                               input string l2);
    logic [8:0] e;
    chk("rf_count", 32'(bq.size() >= base + 34), 1);
    if (bq.size() >= base + 34) begin
      for (int i = 0; i < 34; i++) begin
        if (i == 0)       e = {1'b0, 8'h80};
        else if (i <= 16) e = {1'b1, l1[i-1]};
        else if (i == 17) e = {1'b0, 8'hC0};
        else              e = {1'b1, l2[i-18]};
        chk($sformatf("rf_byte%0d", i), bq[base+i], e);
      end
      chk("rf_span", tq[base+33] - tq[base], 33 * 8);
    end
  endtask

  initial begin
    int rel, t, t1, t2, a0, base;
    rst_ni        = 1'b0;
    refresh_req_i = 1'b0;
    line1_i       = pack(L1);
    line2_i       = pack(L2);
    repeat (3) @(negedge clk);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", data, 0);
    chk("rst_ack", refresh_ack_o, 0);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_busy", busy_o, 1);

    @(posedge clk);
    #2 rst_ni = 1'b1;
    rel = cyc;
    bq.delete();
    tq.delete();
    wait_for(2, 100, t);
    chk("first_e", t - rel, 21);
    wait_for(0, 200, t);
    chk("init_done_at", t - rel, 73);
    chk("auto_ack", refresh_ack_o, 1);
    check_init();
    wait_for(1, 400, t);
    chk("rf1_done_at", t - rel, 346);
    chk("rf1_acks", acks, 1);
    check_refresh(6, L1, L2);

    a0 = acks;
    base = bq.size();
    pulse_req();
    line1_i = pack(L1B);
    wait_for(1, 400, t);
    check_refresh(base, L1, L2);
    repeat (3) @(negedge clk);
    chk("snap_acks", acks - a0, 1);

    a0 = acks;
    pulse_req();
    repeat (30) @(posedge clk);
    pulse_req();
    repeat (30) @(posedge clk);
    pulse_req();
    repeat (30) @(posedge clk);
    pulse_req();
    wait_for(1, 400, t1);
    chk("coll_ack_at_idle", refresh_ack_o, 1);
    base = bq.size();
    @(negedge clk);
    chk("coll_busy_again", busy_o, 1);
    wait_for(1, 400, t2);
    chk("coll_period", t2 - t1, 273);
    chk("coll_no_more_ack", refresh_ack_o, 0);
    repeat (10) @(negedge clk);
    chk("coll_acks", acks - a0, 2);
    check_refresh(base, L1B, L2);

    pulse_req();
    repeat (40) @(negedge clk);
    wait_for(2, 50, t);
    chk("pre_rst_e", lcd_e, 1);
    chk("pre_rst_rs", lcd_rs, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_e", lcd_e, 0);
    chk("async_rs", lcd_rs, 0);
    chk("async_data", data, 0);
    chk("async_init_done", init_done_o, 0);
    chk("async_busy", busy_o, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    rel = cyc;
    bq.delete();
    tq.delete();
    wait_for(2, 100, t);
    chk("re_first_e", t - rel, 21);
    wait_for(0, 200, t);
    chk("re_init_done_at", t - rel, 73);
    chk("re_auto_ack", refresh_ack_o, 1);
    check_init();

    @(posedge clk);
    #2 refresh_req_i = 1'b1;
    a0 = acks;
    wait_for(3, 400, t1);
    chk("cont_ack1_at", t1 - rel, 346);
    wait_for(3, 400, t2);
    chk("cont_period1", t2 - t1, 273);
    wait_for(3, 400, t);
    chk("cont_period2", t - t2, 273);
    @(posedge clk);
    #2 refresh_req_i = 1'b0;
    wait_for(1, 400, t);
    repeat (5) @(negedge clk);
    chk("cont_acks", acks - a0, 3);
    chk("cont_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
